load_store_unit: RTL

//  Executes memory requests issued by the scheduling queue front stage (lsu_rq_*) against an 8-bit memory bus.

---
 rtl/load_store_unit_pkg.sv | 22 ++
 rtl/lsu_req_buffer.sv | 45 ++++
 rtl/load_store_unit.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: FSM states, command/width/tag
// encodings and the byte-lane selection helper.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2
  } lsu_state_e;

  localparam logic LSU_CMD_LOAD  = 1'b0;
  localparam logic LSU_CMD_STORE = 1'b1;
  localparam logic LSU_W_BYTE    = 1'b0;
  localparam logic LSU_W_WORD    = 1'b1;
  localparam logic LSU_TAG_RSA   = 1'b0;
  localparam logic LSU_TAG_RSB   = 1'b1;

  function automatic logic [7:0] lsu_pick_byte(input logic [15:0] data, input logic hi_half);
    return hi_half ? data[15:8] : data[7:0];
  endfunction

endpackage

// File: rtl/lsu_req_buffer.sv
// One-entry skid register holding a request accepted while the unit is busy.
// Push and pop never coincide: the top only accepts while the entry is empty.
module lsu_req_buffer
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              a_rst,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic              i_cmd,
  input  logic              i_width,
  input  logic              i_tag,
  input  logic [ADDR_W-1:0] i_adr,
  input  logic [15:0]       i_data,
  output logic              o_valid,
  output logic              o_cmd,
  output logic              o_width,
  output logic              o_tag,
  output logic [ADDR_W-1:0] o_adr,
  output logic [15:0]       o_data
);

  always_ff @(posedge clk) begin
    if (a_rst) begin
      o_valid <= 1'b0;
      o_cmd   <= LSU_CMD_LOAD;
      o_width <= LSU_W_BYTE;
      o_tag   <= LSU_TAG_RSA;
      o_adr   <= '0;
      o_data  <= '0;
    end else if (i_push) begin
      o_valid <= 1'b1;
      o_cmd   <= i_cmd;
      o_width <= i_width;
      o_tag   <= i_tag;
      o_adr   <= i_adr;
      o_data  <= i_data;
    end else if (i_pop) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: runs byte/word requests as one or two 8-bit bus beats and
// returns tagged load data. Define LSU_REQ_BUF_EN for the one-entry request buffer.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic              clk,
  input  logic              a_rst,
  input  logic              lsu_rq_start,
  input  logic              lsu_rq_cmd,
  input  logic              lsu_rq_width,
  input  logic              lsu_rq_tag,
  input  logic [ADDR_W-1:0] agu_adr,
  input  logic [15:0]       st_data,
  output logic              lsu_wait,
  output logic [15:0]       lsu_data_in,
  output logic              lsu_data_tag,
  output logic              lsu_data_wb,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [7:0]        mem_dout,
  input  logic [7:0]        mem_din,
  input  logic              mem_rdy
);

  lsu_state_e        r_state, w_state_nxt;
  logic              r_cmd, r_width, r_tag;
  logic [ADDR_W-1:0] r_adr;
  logic [15:0]       r_data;
  logic [7:0]        r_lo_byte;
  logic              r_wb, r_data_tag;
  logic [15:0]       r_data_in, w_ld_data;
  logic              w_beat_done, w_last, w_free, w_accept, w_start_new;
  logic              w_nxt_cmd, w_nxt_width, w_nxt_tag;
  logic [ADDR_W-1:0] w_nxt_adr;
  logic [15:0]       w_nxt_data;

  assign w_beat_done = mem_req & mem_rdy;
  assign w_last      = w_beat_done & ((r_state == ST_HI) | (r_width == LSU_W_BYTE));
  assign w_free      = (r_state == ST_IDLE) | w_last;

`ifdef LSU_REQ_BUF_EN
  logic              w_buf_valid, w_buf_cmd, w_buf_width, w_buf_tag;
  logic [ADDR_W-1:0] w_buf_adr;
  logic [15:0]       w_buf_data;

  // A buffered request always has priority; a fresh one bypasses the buffer
  // only when the FSM can take it at this very edge.
  assign lsu_wait    = w_buf_valid;
  assign w_accept    = lsu_rq_start & ~w_buf_valid;
  assign w_start_new = w_free & (w_buf_valid | w_accept);
  assign w_nxt_cmd   = w_buf_valid ? w_buf_cmd   : lsu_rq_cmd;
  assign w_nxt_width = w_buf_valid ? w_buf_width : lsu_rq_width;
  assign w_nxt_tag   = w_buf_valid ? w_buf_tag   : lsu_rq_tag;
  assign w_nxt_adr   = w_buf_valid ? w_buf_adr   : agu_adr;
  assign w_nxt_data  = w_buf_valid ? w_buf_data  : st_data;

  lsu_req_buffer #(.ADDR_W(ADDR_W)) u_req_buffer (
    .clk    (clk),
    .a_rst  (a_rst),
    .i_push (w_accept & ~w_free),
    .i_pop  (w_free & w_buf_valid),
    .i_cmd  (lsu_rq_cmd),
    .i_width(lsu_rq_width),
    .i_tag  (lsu_rq_tag),
    .i_adr  (agu_adr),
    .i_data (st_data),
    .o_valid(w_buf_valid),
    .o_cmd  (w_buf_cmd),
    .o_width(w_buf_width),
    .o_tag  (w_buf_tag),
    .o_adr  (w_buf_adr),
    .o_data (w_buf_data)
  );
`else
  assign lsu_wait    = (r_state != ST_IDLE);
  assign w_accept    = lsu_rq_start & ~lsu_wait;
  assign w_start_new = w_free & w_accept;
  assign w_nxt_cmd   = lsu_rq_cmd;
  assign w_nxt_width = lsu_rq_width;
  assign w_nxt_tag   = lsu_rq_tag;
  assign w_nxt_adr   = agu_adr;
  assign w_nxt_data  = st_data;
`endif

  // NOTE: every signal assigned in an always_comb gets a default first so no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_start_new) w_state_nxt = ST_LO;
      ST_LO:   if (w_beat_done) begin
                 if (r_width == LSU_W_WORD) w_state_nxt = ST_HI;
                 else                       w_state_nxt = w_start_new ? ST_LO : ST_IDLE;
               end
      ST_HI:   if (w_beat_done) w_state_nxt = w_start_new ? ST_LO : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_adr  = '0;
    mem_dout = '0;
    case (r_state)
      ST_LO: begin
        mem_req  = 1'b1;
        mem_we   = (r_cmd == LSU_CMD_STORE);
        mem_adr  = r_adr;
        mem_dout = lsu_pick_byte(r_data, BIG_ENDIAN && (r_width == LSU_W_WORD));
      end
      ST_HI: begin
        mem_req  = 1'b1;
        mem_we   = (r_cmd == LSU_CMD_STORE);
        mem_adr  = r_adr + ADDR_W'(1);
        mem_dout = lsu_pick_byte(r_data, !BIG_ENDIAN);
      end
      default: ;
    endcase
  end

  // The LO beat's byte was captured earlier; the HI byte arrives on mem_din now.
  always_comb begin
    w_ld_data = {8'h00, mem_din};
    if (r_width == LSU_W_WORD)
      w_ld_data = BIG_ENDIAN ? {r_lo_byte, mem_din} : {mem_din, r_lo_byte};
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (a_rst) begin
      r_state    <= ST_IDLE;
      r_cmd      <= LSU_CMD_LOAD;
      r_width    <= LSU_W_BYTE;
      r_tag      <= LSU_TAG_RSA;
      r_adr      <= '0;
      r_data     <= '0;
      r_lo_byte  <= '0;
      r_wb       <= 1'b0;
      r_data_in  <= '0;
      r_data_tag <= LSU_TAG_RSA;
    end else begin
      r_state <= w_state_nxt;
      if (w_start_new) begin
        r_cmd   <= w_nxt_cmd;
        r_width <= w_nxt_width;
        r_tag   <= w_nxt_tag;
        r_adr   <= w_nxt_adr;
        r_data  <= w_nxt_data;
      end
      if ((r_state == ST_LO) && w_beat_done) r_lo_byte <= mem_din;
      r_wb <= w_last && (r_cmd == LSU_CMD_LOAD);
      if (w_last && (r_cmd == LSU_CMD_LOAD)) begin
        r_data_in  <= w_ld_data;
        r_data_tag <= r_tag;
      end
    end
  end

  assign lsu_data_in  = r_data_in;
  assign lsu_data_tag = r_data_tag;
  assign lsu_data_wb  = r_wb;

endmodule
